// File: rtl/mem_ctrl_if.sv
// Request/response and RAM bus bundle for mem_ctrl.
// slave is the controller side, master the pipeline/RAM side.
interface mem_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              if_read;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ready;
  logic [31:0]       if_inst;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [2:0]        mem_length;
  logic              mem_signed;
  logic              mem_ready;
  logic [31:0]       mem_rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_dout;
  logic              ram_wr;
  logic [7:0]        ram_din;

  modport slave (
    input  if_read, if_addr,
    input  mem_read, mem_write, mem_addr,
    input  mem_wdata, mem_length, mem_signed,
    input  ram_din,
    output if_ready, if_inst,
    output mem_ready, mem_rdata,
    output ram_addr, ram_dout, ram_wr
  );

  modport master (
    output if_read, if_addr,
    output mem_read, mem_write, mem_addr,
    output mem_wdata, mem_length, mem_signed,
    output ram_din,
    input  if_ready, if_inst,
    input  mem_ready, mem_rdata,
    input  ram_addr, ram_dout, ram_wr
  );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial RAM controller shared by IF and MEM.
// MEM wins over IF; reads are extended to 32 bits.
module mem_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic     clk,
  input  logic     reset,
  mem_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE, READ, WRITE, DONE
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [2:0]        n_q, n_d;
  logic              own_q, own_d;
  logic              sgn_q, sgn_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       buf_q, buf_d;
  logic              if_ready_q, if_ready_d;
  logic              mem_ready_q, mem_ready_d;
  logic [31:0]       if_inst_q, if_inst_d;
  logic [31:0]       mem_rdata_q, mem_rdata_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [7:0]        ram_dout_q, ram_dout_d;
  logic              ram_wr_q, ram_wr_d;

  logic [2:0]  len_n;
  logic [2:0]  nxt;
  logic [1:0]  bidx;
  logic [31:0] asm_w;
  logic [31:0] ext_w;

  // Decode requested size; anything but 1 or 2 is a word.
  always_comb begin
    len_n = 3'd4;
    unique case (bus.mem_length)
      3'd1:    len_n = 3'd1;
      3'd2:    len_n = 3'd2;
      default: len_n = 3'd4;
    endcase
  end

  // Merge the byte arriving now and extend the result.
  always_comb begin
    nxt   = cnt_q + 3'd1;
    bidx  = cnt_q[1:0] - 2'd1;
    asm_w = buf_q;
    asm_w[{bidx, 3'b000} +: 8] = bus.ram_din;
    unique case (n_q)
      3'd1:    ext_w = {{24{sgn_q & asm_w[7]}}, asm_w[7:0]};
      3'd2:    ext_w = {{16{sgn_q & asm_w[15]}}, asm_w[15:0]};
      default: ext_w = asm_w;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    n_d         = n_q;
    own_d       = own_q;
    sgn_d       = sgn_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    buf_d       = buf_q;
    if_inst_d   = if_inst_q;
    mem_rdata_d = mem_rdata_q;
    if_ready_d  = 1'b0;
    mem_ready_d = 1'b0;
    ram_addr_d  = '0;
    ram_dout_d  = '0;
    ram_wr_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        buf_d = '0;
        if (bus.mem_read || bus.mem_write) begin
          own_d      = 1'b1;
          n_d        = len_n;
          sgn_d      = bus.mem_signed;
          base_d     = bus.mem_addr;
          wdata_d    = bus.mem_wdata;
          ram_addr_d = bus.mem_addr;
          if (bus.mem_read) begin
            state_d = READ;
          end else begin
            state_d    = WRITE;
            ram_wr_d   = 1'b1;
            ram_dout_d = bus.mem_wdata[7:0];
          end
        end else if (bus.if_read) begin
          own_d      = 1'b0;
          n_d        = 3'd4;
          sgn_d      = 1'b0;
          base_d     = bus.if_addr;
          ram_addr_d = bus.if_addr;
          state_d    = READ;
        end
      end
      READ: begin
        if (cnt_q != 3'd0) buf_d = asm_w;
        if (cnt_q == n_q) begin
          state_d = DONE;
          if (own_q) begin
            mem_ready_d = 1'b1;
            mem_rdata_d = ext_w;
          end else begin
            if_ready_d = 1'b1;
            if_inst_d  = ext_w;
          end
        end else begin
          cnt_d = nxt;
          if (nxt != n_q)
            ram_addr_d = base_q + ADDR_W'(nxt);
        end
      end
      WRITE: begin
        if (nxt == n_q) begin
          state_d     = DONE;
          mem_ready_d = 1'b1;
        end else begin
          cnt_d      = nxt;
          ram_wr_d   = 1'b1;
          ram_addr_d = base_q + ADDR_W'(nxt);
          ram_dout_d = wdata_q[{nxt[1:0], 3'b000} +: 8];
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      n_q         <= 3'd4;
      own_q       <= 1'b0;
      sgn_q       <= 1'b0;
      base_q      <= '0;
      wdata_q     <= '0;
      buf_q       <= '0;
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      if_inst_q   <= '0;
      mem_rdata_q <= '0;
      ram_addr_q  <= '0;
      ram_dout_q  <= '0;
      ram_wr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      n_q         <= n_d;
      own_q       <= own_d;
      sgn_q       <= sgn_d;
      base_q      <= base_d;
      wdata_q     <= wdata_d;
      buf_q       <= buf_d;
      if_ready_q  <= if_ready_d;
      mem_ready_q <= mem_ready_d;
      if_inst_q   <= if_inst_d;
      mem_rdata_q <= mem_rdata_d;
      ram_addr_q  <= ram_addr_d;
      ram_dout_q  <= ram_dout_d;
      ram_wr_q    <= ram_wr_d;
    end
  end

  assign bus.if_ready  = if_ready_q;
  assign bus.if_inst   = if_inst_q;
  assign bus.mem_ready = mem_ready_q;
  assign bus.mem_rdata = mem_rdata_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_dout  = ram_dout_q;
  assign bus.ram_wr    = ram_wr_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: RAM model, per-cycle reference
// schedule, directed cases and randomized traffic.
module tb_mem_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  mem_ctrl_if #(.ADDR_W(32)) bus ();

  mem_ctrl #(.ADDR_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] ram_m [logic [31:0]];
  logic [7:0] sh_m  [logic [31:0]];

  function automatic logic [7:0] dflt(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram_m.exists(a) ? ram_m[a] : dflt(a);
  endfunction

  function automatic logic [7:0] sh_rd(input logic [31:0] a);
    return sh_m.exists(a) ? sh_m[a] : dflt(a);
  endfunction

  task automatic poke(input logic [31:0] a, input logic [7:0] b);
    ram_m[a] = b;
    sh_m[a]  = b;
  endtask

  // Byte RAM: one-cycle read latency, write at the edge.
  always @(posedge clk) begin
    bus.ram_din <= ram_rd(bus.ram_addr);
    if (bus.ram_wr === 1'b1) ram_m[bus.ram_addr] = bus.ram_dout;
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [7:0]  dout;
    logic        ifr;
    logic        mr;
    logic        ld;
    logic [31:0] data;
  } rec_t;

  rec_t        sched[$];
  rec_t        r_m;
  logic        busy_m;
  logic        armed = 1'b0;
  logic [31:0] e_inst = '0;
  logic [31:0] e_rdata = '0;

  function automatic int nlen(input logic [2:0] l);
    return (l == 3'd1) ? 1 : (l == 3'd2) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a,
                                             input int n, input logic sg);
    logic [31:0] v;
    v = '0;
    for (int k = 0; k < n; k++) v[8*k +: 8] = sh_rd(a + k);
    if (sg && n == 1 && v[7])  v[31:8]  = '1;
    if (sg && n == 2 && v[15]) v[31:16] = '1;
    return v;
  endfunction

  task automatic push_read(input logic [31:0] a, input int n,
                           input logic sg, input logic own_mem);
    logic [31:0] d;
    d = model_load(a, n, sg);
    for (int k = 0; k < n; k++)
      sched.push_back('{addr: a + k, wr: 0, dout: 0, ifr: 0,
                        mr: 0, ld: 0, data: 0});
    sched.push_back('{addr: 0, wr: 0, dout: 0, ifr: 0,
                      mr: 0, ld: 0, data: 0});
    sched.push_back('{addr: 0, wr: 0, dout: 0, ifr: !own_mem,
                      mr: own_mem, ld: 1, data: d});
  endtask

  task automatic push_write(input logic [31:0] a, input int n,
                            input logic [31:0] wd);
    for (int k = 0; k < n; k++)
      sched.push_back('{addr: a + k, wr: 1, dout: wd[8*k +: 8],
                        ifr: 0, mr: 0, ld: 0, data: 0});
    sched.push_back('{addr: 0, wr: 0, dout: 0, ifr: 0,
                      mr: 1, ld: 0, data: 0});
  endtask

  // Compare DUT outputs to the expected schedule each cycle.
  always @(negedge clk) begin
    busy_m = (sched.size() != 0);
    r_m = '{addr: 0, wr: 0, dout: 0, ifr: 0, mr: 0, ld: 0, data: 0};
    if (busy_m) r_m = sched.pop_front();
    if (r_m.ld && r_m.ifr) e_inst  = r_m.data;
    if (r_m.ld && r_m.mr)  e_rdata = r_m.data;
    if (armed) begin
      chk("ram_bus", 64'({bus.ram_addr, bus.ram_wr, bus.ram_dout}),
          64'({r_m.addr, r_m.wr, r_m.dout}));
      chk("ready", 64'({bus.if_ready, bus.mem_ready}),
          64'({r_m.ifr, r_m.mr}));
      chk("data", {bus.if_inst, bus.mem_rdata}, {e_inst, e_rdata});
    end
    if (r_m.wr) sh_m[r_m.addr] = r_m.dout;
    if (reset) begin
      armed = 1'b1;
      sched.delete();
      e_inst  = '0;
      e_rdata = '0;
    end else if (armed && !busy_m) begin
      if (bus.mem_read)
        push_read(bus.mem_addr, nlen(bus.mem_length),
                  bus.mem_signed, 1'b1);
      else if (bus.mem_write)
        push_write(bus.mem_addr, nlen(bus.mem_length), bus.mem_wdata);
      else if (bus.if_read)
        push_read(bus.if_addr, 4, 1'b0, 1'b0);
    end
  end

  // ---------------- requesters ----------------
  task automatic mem_op(input bit rd, input logic [31:0] a,
                        input logic [2:0] len, input bit sg,
                        input logic [31:0] wd, input bit scr,
                        output logic [31:0] data, output int lat);
    int t0;
    bit got;
    data = '0;
    lat  = -1;
    got  = 0;
    bus.mem_addr   = a;
    bus.mem_length = len;
    bus.mem_signed = sg;
    bus.mem_wdata  = wd;
    bus.mem_read   = rd;
    bus.mem_write  = !rd;
    t0 = cyc;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (scr && i == 1) begin
        bus.mem_addr   = $urandom;
        bus.mem_wdata  = $urandom;
        bus.mem_length = 3'($urandom_range(0, 7));
        bus.mem_signed = 1'($urandom_range(0, 1));
      end
      if (bus.mem_ready) begin
        got  = 1;
        data = bus.mem_rdata;
        lat  = cyc - t0;
      end
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL mem_timeout cyc=%0d got=none want=mem_ready", cyc);
    end
    @(posedge clk);
    #1;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
  endtask

  task automatic if_op(input logic [31:0] a,
                       output logic [31:0] data, output int lat);
    int t0;
    bit got;
    data = '0;
    lat  = -1;
    got  = 0;
    bus.if_addr = a;
    bus.if_read = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (bus.if_ready) begin
        got  = 1;
        data = bus.if_inst;
        lat  = cyc - t0;
      end
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL if_timeout cyc=%0d got=none want=if_ready", cyc);
    end
    @(posedge clk);
    #1;
    bus.if_read = 1'b0;
  endtask

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog cyc=%0d got=hang want=finish", cyc);
    $fatal(1, "watchdog");
  end

  logic [31:0] d, d2;
  int          lat, lat2;

  initial begin
    bus.if_read    = 1'b0;
    bus.if_addr    = '0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    bus.mem_length = 3'd4;
    bus.mem_signed = 1'b0;
    poke(32'h100, 8'h13); poke(32'h101, 8'h05);
    poke(32'h102, 8'h10); poke(32'h103, 8'h00);
    poke(32'h20, 8'h80);
    poke(32'h40, 8'h11); poke(32'h41, 8'h22);
    poke(32'h42, 8'h33); poke(32'h43, 8'h44);
    poke(32'h60, 8'h34); poke(32'h61, 8'h92);
    poke(32'h200, 8'h01); poke(32'h201, 8'h02);
    poke(32'h202, 8'h03); poke(32'h203, 8'h04);
    poke(32'h300, 8'hA1); poke(32'h301, 8'hB2);
    poke(32'h302, 8'hC3); poke(32'h303, 8'hD4);
    for (int k = 0; k < 4; k++) poke(32'h80 + k, 8'h00);
    poke(32'hFFFF_FFFE, 8'h11); poke(32'hFFFF_FFFF, 8'h22);
    poke(32'h0, 8'h33); poke(32'h1, 8'h44);

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_out", 64'({bus.if_ready, bus.mem_ready, bus.ram_wr,
                          bus.ram_addr, bus.ram_dout}), 64'd0);
    chk("reset_data", {bus.if_inst, bus.mem_rdata}, 64'd0);
    @(posedge clk);
    #1;

    if_op(32'h100, d, lat);
    chk("if_word", 64'(d), 64'h0010_0513);
    chk("if_lat", 64'(lat), 64'd6);

    mem_op(1, 32'h20, 3'd1, 1, 32'h0, 0, d, lat);
    chk("lb_signed", 64'(d), 64'hFFFF_FF80);
    mem_op(1, 32'h20, 3'd1, 0, 32'h0, 0, d, lat);
    chk("lb_unsigned", 64'(d), 64'h0000_0080);
    chk("lb_lat", 64'(lat), 64'd3);
    mem_op(1, 32'h60, 3'd2, 1, 32'h0, 0, d, lat);
    chk("lh_signed", 64'(d), 64'hFFFF_9234);

    mem_op(0, 32'h40, 3'd2, 0, 32'hDEAD_BEEF, 0, d, lat);
    chk("sh_lat", 64'(lat), 64'd3);
    mem_op(1, 32'h40, 3'd4, 0, 32'h0, 0, d, lat);
    chk("sh_readback", 64'(d), 64'h4433_BEEF);

    fork
      mem_op(1, 32'h300, 3'd4, 0, 32'h0, 0, d, lat);
      if_op(32'h200, d2, lat2);
    join
    chk("arb_mem", 64'(d), 64'hD4C3_B2A1);
    chk("arb_mem_lat", 64'(lat), 64'd6);
    chk("arb_if", 64'(d2), 64'h0403_0201);
    chk("arb_if_lat", 64'(lat2), 64'd13);

    bus.mem_addr   = 32'h80;
    bus.mem_wdata  = 32'hCAFE_F00D;
    bus.mem_length = 3'd4;
    bus.mem_write  = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 reset = 1'b1;
    bus.mem_write = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("abort_wr", 64'({bus.ram_wr, bus.mem_ready}), 64'd0);
    @(posedge clk);
    #1;
    mem_op(1, 32'h80, 3'd4, 0, 32'h0, 0, d, lat);
    chk("abort_readback", 64'(d), 64'h0000_F00D);

    mem_op(1, 32'hFFFF_FFFE, 3'd4, 1, 32'h0, 0, d, lat);
    chk("wrap_word", 64'(d), 64'h4433_2211);

    for (int it = 0; it < 200; it++) begin
      logic [31:0] ra, ia, wd;
      logic [2:0]  ln;
      bit          rd, sg;
      int          mode;
      ra   = ($urandom_range(0, 1) == 1) ?
             (32'h1000 + 32'($urandom_range(0, 31))) : $urandom;
      ia   = ($urandom_range(0, 1) == 1) ?
             (32'h1000 + 32'($urandom_range(0, 31))) : $urandom;
      wd   = $urandom;
      ln   = 3'($urandom_range(0, 7));
      rd   = 1'($urandom_range(0, 1));
      sg   = 1'($urandom_range(0, 1));
      mode = $urandom_range(0, 2);
      if (mode == 0) begin
        mem_op(rd, ra, ln, sg, wd, 1'($urandom_range(0, 1)), d, lat);
      end else if (mode == 1) begin
        if_op(ia, d, lat);
      end else begin
        fork
          mem_op(rd, ra, ln, sg, wd, 0, d, lat);
          if_op(ia, d2, lat2);
        join
      end
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end

    repeat (4) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
